// File: rtl/shifter_pipe_if.sv
// Handshake and data bundle for the pipelined barrel shifter.
// master drives words in and accepts results; slave is the shifter.
interface shifter_pipe_if #(
  parameter int WIDTH = 32
) ();
  localparam int AMT_W = $clog2(WIDTH);

  logic             IN_VALID;
  logic             IN_READY;
  logic [1:0]       SH_MODE;
  logic [AMT_W-1:0] SH_AMT;
  logic [WIDTH-1:0] D_IN;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] D_OUT;
  logic             ZERO;

  modport master (
    output IN_VALID, SH_MODE, SH_AMT, D_IN, OUT_READY,
    input  IN_READY, OUT_VALID, D_OUT, ZERO
  );

  modport slave (
    input  IN_VALID, SH_MODE, SH_AMT, D_IN, OUT_READY,
    output IN_READY, OUT_VALID, D_OUT, ZERO
  );
endinterface

// File: rtl/shifter_pipe.sv
// Pipelined logarithmic barrel shifter: stage k shifts by 2^k when amount bit k is set.
// Global-stall flow control; results come straight from the last stage registers.
module shifter_pipe #(
  parameter int WIDTH = 32
) (
  input logic           CLK,
  input logic           RST,
  shifter_pipe_if.slave bus
);
  localparam int AMT_W = $clog2(WIDTH);

  logic advance;

  for (genvar gi = 0; gi < AMT_W; gi++) begin : g_stage
    localparam int SH = 1 << gi;
    // Each stage only carries the amount bits that later stages still need.
    localparam int RW = AMT_W - gi;

    logic             valid_in;
    logic [1:0]       mode_in;
    logic [RW-1:0]    amt_in;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] shifted;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    if (gi == 0) begin : g_src
      assign valid_in = bus.IN_VALID;
      assign mode_in  = bus.SH_MODE;
      assign amt_in   = bus.SH_AMT;
      assign data_in  = bus.D_IN;
    end else begin : g_src
      assign valid_in = g_stage[gi-1].valid_q;
      assign mode_in  = g_stage[gi-1].g_fwd.mode_q;
      assign amt_in   = g_stage[gi-1].g_fwd.amt_q;
      assign data_in  = g_stage[gi-1].data_q;
    end

    always_comb begin
      shifted = data_in;
      if (amt_in[0]) begin
        case (mode_in)
          2'b00:   shifted = {data_in[WIDTH-1-SH:0], {SH{1'b0}}};
          2'b01:   shifted = {{SH{1'b0}}, data_in[WIDTH-1:SH]};
          2'b10:   shifted = {{SH{data_in[WIDTH-1]}}, data_in[WIDTH-1:SH]};
          default: shifted = {data_in[SH-1:0], data_in[WIDTH-1:SH]};
        endcase
      end
    end

    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (advance) begin
        valid_d = valid_in;
        data_d  = shifted;
      end
    end

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
      end
    end

    if (gi < AMT_W - 1) begin : g_fwd
      logic [1:0]    mode_q, mode_d;
      logic [RW-2:0] amt_q, amt_d;

      always_comb begin
        mode_d = mode_q;
        amt_d  = amt_q;
        if (advance) begin
          mode_d = mode_in;
          amt_d  = amt_in[RW-1:1];
        end
      end

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          mode_q <= '0;
          amt_q  <= '0;
        end else begin
          mode_q <= mode_d;
          amt_q  <= amt_d;
        end
      end
    end
  end

  // Bubbles are held along with valid words; the pipe only moves as a whole.
  assign advance       = !g_stage[AMT_W-1].valid_q || bus.OUT_READY;
  assign bus.IN_READY  = advance;
  assign bus.OUT_VALID = g_stage[AMT_W-1].valid_q;
  assign bus.D_OUT     = g_stage[AMT_W-1].data_q;
  assign bus.ZERO      = (g_stage[AMT_W-1].data_q == '0);
endmodule

// File: tb/tb_shifter_pipe.sv
// Self-checking bench for shifter_pipe: directed vectors, random streaming,
// backpressure and mid-flight reset, scored against a whole-amount shift model.
module tb_shifter_pipe;
  localparam int W   = 32;
  localparam int LAT = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   out_cnt = 0;
  logic [W-1:0] exp_q[$];

  shifter_pipe_if #(.WIDTH(W)) bus ();

  shifter_pipe #(.WIDTH(W)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   mode;
    logic [4:0]   amt;
    logic [W-1:0] din;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [W-1:0] ref_shift(input logic [1:0] m, input int amt,
                                             input logic [W-1:0] d);
    logic [2*W-1:0] dd;
    case (m)
      2'b00:   return d << amt;
      2'b01:   return d >> amt;
      2'b10:   return W'($signed(d) >>> amt);
      default: begin
        dd = {d, d} >> amt;
        return dd[W-1:0];
      end
    endcase
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and protocol monitor, sampled mid-cycle.
  initial begin
    logic         prev_stall;
    logic [W-1:0] prev_dout;
    logic [W-1:0] e;
    prev_stall = 1'b0;
    prev_dout  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        prev_stall = 1'b0;
      end else begin
        check("in_ready_rule", W'(bus.IN_READY), W'(!bus.OUT_VALID || bus.OUT_READY));
        if (prev_stall) begin
          check("stall_valid", W'(bus.OUT_VALID), W'(1));
          check("stall_dout", bus.D_OUT, prev_dout);
        end
        if (bus.OUT_VALID && bus.OUT_READY) begin
          out_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %h, expected no result", bus.D_OUT);
          end else begin
            e = exp_q.pop_front();
            check("model_dout", bus.D_OUT, e);
            check("model_zero", W'(bus.ZERO), W'(e == '0));
          end
        end
        if (bus.IN_VALID && bus.IN_READY)
          exp_q.push_back(ref_shift(bus.SH_MODE, int'(bus.SH_AMT), bus.D_IN));
        prev_stall = bus.OUT_VALID && !bus.OUT_READY;
        prev_dout  = bus.D_OUT;
      end
    end
  end

  task automatic apply_vec(input vec_t v, input int idx);
    int n;
    bus.OUT_READY = 1'b1;
    bus.SH_MODE   = v.mode;
    bus.SH_AMT    = v.amt;
    bus.D_IN      = v.din;
    bus.IN_VALID  = 1'b1;
    tick();
    bus.IN_VALID = 1'b0;
    n = 1;
    while (!bus.OUT_VALID && n < 20) begin
      tick();
      n++;
    end
    check($sformatf("vec%0d_latency", idx), W'(n), W'(LAT));
    check($sformatf("vec%0d_dout", idx), bus.D_OUT, v.exp);
    check($sformatf("vec%0d_zero", idx), W'(bus.ZERO), W'(v.exp == '0));
    tick();
  endtask

  initial begin
    int first_i, last_i, nvalid, idx, cyc, base_cnt;
    logic acc;
    logic [W-1:0] words[8];
    logic [1:0]   modes[8];
    logic [4:0]   amts[8];

    vecs[0] = '{2'b00, 5'd31, 32'h0000_0001, 32'h8000_0000};
    vecs[1] = '{2'b10, 5'd4,  32'hF000_0000, 32'hFF00_0000};
    vecs[2] = '{2'b01, 5'd4,  32'hF000_0000, 32'h0F00_0000};
    vecs[3] = '{2'b00, 5'd0,  32'hF000_0000, 32'hF000_0000};
    vecs[4] = '{2'b01, 5'd0,  32'hF000_0000, 32'hF000_0000};
    vecs[5] = '{2'b10, 5'd0,  32'hF000_0000, 32'hF000_0000};
    vecs[6] = '{2'b11, 5'd0,  32'hF000_0000, 32'hF000_0000};
    vecs[7] = '{2'b11, 5'd8,  32'h0000_00A5, 32'hA500_0000};
    vecs[8] = '{2'b00, 5'd1,  32'h8000_0000, 32'h0000_0000};
    vecs[9] = '{2'b11, 5'd4,  32'h0000_000F, 32'hF000_0000};

    bus.IN_VALID  = 1'b0;
    bus.OUT_READY = 1'b0;
    bus.SH_MODE   = 2'b00;
    bus.SH_AMT    = '0;
    bus.D_IN      = '0;

    #12;
    check("reset_out_valid", W'(bus.OUT_VALID), W'(0));
    check("reset_dout", bus.D_OUT, '0);
    check("reset_zero", W'(bus.ZERO), W'(1));
    check("reset_in_ready", W'(bus.IN_READY), W'(1));
    @(posedge clk);
    #3 rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) apply_vec(vecs[i], i);

    // Back-to-back streaming
    bus.OUT_READY = 1'b1;
    first_i = -1;
    last_i  = -1;
    nvalid  = 0;
    for (int i = 0; i < 40; i++) begin
      bus.IN_VALID = (i < 20);
      bus.SH_MODE  = 2'($urandom_range(0, 3));
      bus.SH_AMT   = 5'($urandom_range(0, 31));
      bus.D_IN     = $urandom;
      if (i < 20) check("stream_in_ready", W'(bus.IN_READY), W'(1));
      tick();
      if (bus.OUT_VALID) begin
        if (first_i < 0) first_i = i;
        last_i = i;
        nvalid++;
      end
    end
    check("stream_count", W'(nvalid), W'(20));
    check("stream_first", W'(first_i), W'(LAT - 1));
    check("stream_consecutive", W'(last_i - first_i), W'(19));

    // Backpressure
    for (int i = 0; i < 8; i++) begin
      words[i] = $urandom;
      modes[i] = 2'($urandom_range(0, 3));
      amts[i]  = 5'($urandom_range(0, 31));
    end
    base_cnt = out_cnt;
    idx = 0;
    cyc = 0;
    while ((idx < 8 || exp_q.size() > 0) && cyc < 200) begin
      bus.OUT_READY = (cyc >= 4 && cyc <= 9) ? 1'b0 : 1'($urandom_range(0, 1));
      bus.IN_VALID  = (idx < 8);
      if (idx < 8) begin
        bus.D_IN    = words[idx];
        bus.SH_MODE = modes[idx];
        bus.SH_AMT  = amts[idx];
      end
      #2 acc = bus.IN_VALID && bus.IN_READY;
      @(posedge clk);
      #1;
      if (acc) idx++;
      cyc++;
    end
    bus.IN_VALID = 1'b0;
    check("bp_drained", W'(exp_q.size()), W'(0));
    check("bp_delivered", W'(out_cnt - base_cnt), W'(8));

    // Mid-flight reset with results stalled at the output
    bus.OUT_READY = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.IN_VALID = 1'b1;
      bus.SH_MODE  = 2'b00;
      bus.SH_AMT   = 5'(i + 1);
      bus.D_IN     = 32'h0000_0F00 + W'(i);
      tick();
    end
    bus.IN_VALID = 1'b0;
    cyc = 0;
    while (!bus.OUT_VALID && cyc < 20) begin
      tick();
      cyc++;
    end
    check("pre_reset_valid", W'(bus.OUT_VALID), W'(1));
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst_valid", W'(bus.OUT_VALID), W'(0));
    check("async_rst_dout", bus.D_OUT, '0);
    check("async_rst_zero", W'(bus.ZERO), W'(1));
    check("async_rst_in_ready", W'(bus.IN_READY), W'(1));
    tick();
    @(posedge clk);
    #3 rst = 1'b0;
    bus.OUT_READY = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.OUT_VALID) nvalid++;
    end
    check("no_stale_results", W'(nvalid), W'(0));
    apply_vec('{2'b01, 5'd4, 32'h1234_5678, 32'h0123_4567}, 10);

    repeat (3) tick();
    check("final_queue_empty", W'(exp_q.size()), W'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/shifter_pipe.md
Name: shifter_pipe

Overview:
- Parametrised, pipelined logarithmic barrel shifter. Next generation of the single-stage shift-by-2 shifter used in the ch4 datapath.
- One registered stage per amount bit; stage k shifts by 2^k when SH_AMT bit k is set.
- Supports four shift modes: logical left, logical right, arithmetic right, rotate right.
- Valid/ready handshake on input and output so it can sit between the register file read stage and the ALU writeback stage.

Parameters:
- WIDTH, 32, data width in bits; must be a power of two and >= 4.
- AMT_W, $clog2(WIDTH), shift amount width; derived, must not be overridden.

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  asynchronous, active-high reset
- IN_VALID  input  1  input word present
- IN_READY  output  1  block accepts input this cycle
- SH_MODE  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
- SH_AMT  input  AMT_W  shift amount, 0..WIDTH-1
- D_IN  input  WIDTH  data to shift
- OUT_VALID  output  1  D_OUT holds a valid result
- OUT_READY  input  1  downstream accepts result
- D_OUT  output  WIDTH  shifted result
- ZERO  output  1  D_OUT == 0; qualified by OUT_VALID

Behaviour:
- Reset (async, RST=1): all stage valid bits clear, all data/amount/mode registers 0. OUT_VALID=0, D_OUT=0, ZERO=1 (D_OUT is zero). IN_READY=1 one combinational step after reset: RST does not gate IN_READY.
- Pipeline: AMT_W register stages S0..S(AMT_W-1), each holding valid, mode, amount, data.
- Stage k input comes from stage k-1; stage 0 input comes from the ports.
- Stage k output: if amount bit k = 0, data passes unchanged. If amount bit k = 1, the shift is by 2^k:
  - LSL: shift left, zero fill.
  - LSR: shift right, zero fill.
  - ASR: shift right, fill with the current MSB of the stage data. The MSB is preserved through all stages, so the final result equals the signed arithmetic shift of D_IN.
  - ROR: rotate right, with the low 2^k bits wrapping to the top.
- Latency: exactly AMT_W cycles from an accepted input to OUT_VALID, with no stall. Default is 5 cycles.
- Throughput: one word per cycle.
- D_OUT/OUT_VALID come straight from the last stage registers; there is no combinational path from D_IN to D_OUT.
- Flow control uses a global stall, with advance = !OUT_VALID || OUT_READY.
  - IN_READY = advance.
  - Input accept happens when IN_VALID && IN_READY.
  - When advance=1, every stage loads from its predecessor. Stage 0 valid := IN_VALID.
  - When advance=0, all stages hold their contents, including bubbles. Bubbles are not compressed.
- Output handshake: a result transfers on OUT_VALID && OUT_READY. While OUT_VALID=1 and OUT_READY=0, D_OUT, ZERO and OUT_VALID must stay stable.
- Data and amount registers may load unconditionally when advance=1, even for invalid slots. Only the valid bits are observable.
- Amount 0: output equals input for all modes. Amount is never >= WIDTH, because of the port width.
- Simultaneous output drain and new input accept in the same cycle: both take effect, no loss or duplication.
- Reset mid-operation: all in-flight words are discarded. OUT_VALID drops immediately, asynchronously. No result is produced for words accepted before reset.
- ZERO is combinational from D_OUT.

Test Plan:
- Reset then single LSL: D_IN=32'h0000_0001, SH_AMT=31, SH_MODE=00, one-cycle IN_VALID, OUT_READY=1 -> OUT_VALID exactly 5 cycles later with D_OUT=32'h8000_0000, ZERO=0.
- ASR/LSR sign handling: D_IN=32'hF000_0000, AMT=4 -> ASR gives 32'hFF00_0000; LSR gives 32'h0F00_0000. AMT=0 with every mode -> 32'hF000_0000.
- ROR wrap and ZERO: D_IN=32'h0000_00A5, AMT=8, ROR -> 32'hA500_0000. Then LSL of 32'h8000_0000 by 1 -> D_OUT=0, ZERO=1.
- Back-to-back streaming: 20 consecutive random words and modes with IN_VALID=1, OUT_READY=1 -> 20 results in order on consecutive cycles after 5-cycle latency, each matching the reference model, IN_READY constantly 1.
- Backpressure: stream 8 words while OUT_READY toggles randomly, including a 6-cycle low period -> IN_READY equals !OUT_VALID||OUT_READY every cycle; D_OUT stable while stalled; all 8 results delivered in order with no drop or duplicate.
- Reset mid-flight: accept 3 words, assert RST asynchronously between clock edges after 2 cycles -> OUT_VALID=0 and D_OUT=0 immediately. After release, no stale results appear; a new word D_IN=32'h1234_5678, LSR by 4 -> 32'h0123_4567 after 5 cycles.
